// File: rtl/harness_pkg.sv
// Shared constants and types for the delay-line harness UART command controller.
package harness_pkg;

    localparam logic [7:0] CMD_LEN     = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_RUN     = 8'h52;  // 'R'
    localparam logic [7:0] CMD_STOP    = 8'h53;  // 'S'
    localparam logic [7:0] CMD_QUERY   = 8'h51;  // 'Q'

    localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR     = 8'h45;  // 'E'
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T'

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GET_ARG,
        ST_RESP
    } state_t;

    function automatic int unsigned delay_bytes(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/harness_tx_mux.sv
// Single UART TX output register shared by command responses (priority) and streamed samples.
module harness_tx_mux (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       i_resp_valid,
    input  logic [7:0] i_resp_data,
    output logic       o_resp_taken,
    input  logic       i_run,
    input  logic       i_samp_valid,
    input  logic [7:0] i_samp_data,
    output logic       o_samp_ready,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready
);

    logic       r_tx_valid;
    logic [7:0] r_tx_data;
    logic       w_can_load;
    logic       w_take_resp;
    logic       w_take_samp;

    // The register may be refilled in the same cycle its current byte is accepted.
    assign w_can_load  = !r_tx_valid || i_tx_ready;
    assign w_take_resp = w_can_load && i_resp_valid;
    assign w_take_samp = n_reset && w_can_load && !i_resp_valid && i_run && i_samp_valid;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else if (w_take_resp) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= i_resp_data;
        end else if (w_take_samp) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= i_samp_data;
        end else if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign o_resp_taken = w_take_resp;
    assign o_samp_ready = w_take_samp;
    assign o_tx_valid   = r_tx_valid;
    assign o_tx_data    = r_tx_data;

endmodule

// File: rtl/harness_cmd_ctrl.sv
// UART command decoder for the delay-line harness: sets delay_len, starts/stops the datapath.
// Optional argument timeout is built only when HARNESS_CMD_TIMEOUT_EN is defined.
module harness_cmd_ctrl
    import harness_pkg::*;
#(
    parameter int unsigned DELAY_W        = 16,
    parameter int unsigned DELAY_RESET    = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [7:0]         samp_data,
    input  logic               samp_valid,
    output logic               samp_ready,
    output logic [DELAY_W-1:0] delay_len,
    output logic               run
);

    localparam int unsigned DELAY_BYTES = delay_bytes(DELAY_W);
    localparam int unsigned CNT_W       = (DELAY_BYTES > 1) ? $clog2(DELAY_BYTES) : 1;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [DELAY_W-1:0] r_shadow, w_shadow_next;
    logic [DELAY_W-1:0] r_delay_len, w_delay_next;
    logic               r_run, w_run_next;
    logic               r_overrun, w_overrun_next;
    logic [7:0]         r_resp_data, w_resp_data_next;
    logic               r_resp_is_status, w_resp_is_status_next;
    logic [DELAY_W-1:0] w_arg;
    logic [7:0]         w_resp_byte;
    logic               w_resp_taken;
    logic               w_timeout;

    assign w_arg = (r_shadow << 8) | DELAY_W'(rx_data);

`ifdef HARNESS_CMD_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] r_timer;

    always_ff @(posedge clk) begin
        if (!n_reset || r_state != ST_GET_ARG || rx_valid) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_GET_ARG) && !rx_valid &&
                       (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_shadow         <= '0;
            r_delay_len      <= DELAY_W'(DELAY_RESET);
            r_run            <= 1'b0;
            r_overrun        <= 1'b0;
            r_resp_data      <= 8'h00;
            r_resp_is_status <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_cnt            <= w_cnt_next;
            r_shadow         <= w_shadow_next;
            r_delay_len      <= w_delay_next;
            r_run            <= w_run_next;
            r_overrun        <= w_overrun_next;
            r_resp_data      <= w_resp_data_next;
            r_resp_is_status <= w_resp_is_status_next;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no branch leaves a signal unassigned and infers a latch.
        w_state_next          = r_state;
        w_cnt_next            = r_cnt;
        w_shadow_next         = r_shadow;
        w_delay_next          = r_delay_len;
        w_run_next            = r_run;
        w_overrun_next        = r_overrun;
        w_resp_data_next      = r_resp_data;
        w_resp_is_status_next = r_resp_is_status;

        case (r_state)
            ST_IDLE: begin
                if (rx_valid) begin
                    w_state_next          = ST_RESP;
                    w_resp_data_next      = RSP_OK;
                    w_resp_is_status_next = 1'b0;
                    case (rx_data)
                        CMD_LEN: begin
                            w_state_next  = ST_GET_ARG;
                            w_cnt_next    = '0;
                            w_shadow_next = '0;
                        end
                        CMD_RUN:   w_run_next            = 1'b1;
                        CMD_STOP:  w_run_next            = 1'b0;
                        CMD_QUERY: w_resp_is_status_next = 1'b1;
                        default:   w_resp_data_next      = RSP_ERR;
                    endcase
                end
            end
            ST_GET_ARG: begin
                if (rx_valid) begin
                    w_shadow_next = w_arg;
                    if (r_cnt == CNT_W'(DELAY_BYTES - 1)) begin
                        w_state_next          = ST_RESP;
                        w_resp_is_status_next = 1'b0;
                        if (w_arg != '0) begin
                            w_delay_next     = w_arg;
                            w_resp_data_next = RSP_OK;
                        end else begin
                            w_resp_data_next = RSP_ERR;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_next          = ST_RESP;
                    w_resp_is_status_next = 1'b0;
                    w_resp_data_next      = RSP_TIMEOUT;
                end
            end
            ST_RESP: begin
                // A byte arriving while a response waits is lost; that loss outranks a status clear.
                if (rx_valid) begin
                    w_overrun_next = 1'b1;
                end else if (w_resp_taken && r_resp_is_status) begin
                    w_overrun_next = 1'b0;
                end
                if (w_resp_taken) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Status is built when it loads, so it reports overrun events up to that moment.
    assign w_resp_byte = r_resp_is_status ? {6'b0, r_overrun, r_run} : r_resp_data;

    harness_tx_mux u_tx_mux (
        .clk          (clk),
        .n_reset      (n_reset),
        .i_resp_valid (r_state == ST_RESP),
        .i_resp_data  (w_resp_byte),
        .o_resp_taken (w_resp_taken),
        .i_run        (r_run),
        .i_samp_valid (samp_valid),
        .i_samp_data  (samp_data),
        .o_samp_ready (samp_ready),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready)
    );

    assign delay_len = r_delay_len;
    assign run       = r_run;

endmodule

// File: tb/tb_harness_cmd_ctrl.sv
// Self-checking bench for harness_cmd_ctrl: command table, multi-cycle sequences, random commands.
module tb_harness_cmd_ctrl;

    localparam int DW   = 16;
    localparam int DRST = 1024;
    localparam int TMO  = 200;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [7:0]    samp_data = 8'h77;
    logic          samp_valid = 1'b1;
    logic          samp_ready;
    logic [DW-1:0] delay_len;
    logic          run;

    int         n_total = 0;
    int         n_bad = 0;
    int         samp_loads = 0;
    int         ready_mode = 0;  // 0: main drives, 1: random, 2: toggle
    logic [7:0] rcv_q[$];
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    logic [DW-1:0] m_delay;
    logic          m_run;
    logic          m_ovr;

    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2;
        logic [7:0] rsp;
        logic [15:0] dly;
        logic       run;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    harness_cmd_ctrl #(
        .DELAY_W        (DW),
        .DELAY_RESET    (DRST),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .samp_data  (samp_data),
        .samp_valid (samp_valid),
        .samp_ready (samp_ready),
        .delay_len  (delay_len),
        .run        (run)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rsp(input string name, input logic [7:0] exp);
        int i;
        i = 0;
        while (rcv_q.size() == 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (rcv_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: no tx byte within 200 cycles, expected 0x%02h", name, exp);
        end else begin
            check(name, 32'(rcv_q.pop_front()), 32'(exp));
        end
    endtask

    // Observes the TX and sample handshakes just before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!n_reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("tx_hold_valid", 32'(tx_valid), 32'd1);
                    check("tx_hold_data", 32'(tx_data), 32'(prev_data));
                end
                if (tx_valid && tx_ready) rcv_q.push_back(tx_data);
                if (samp_ready) begin
                    samp_loads++;
                    check("samp_ready_gated", 32'(run && samp_valid), 32'd1);
                end
                prev_hold = tx_valid && !tx_ready;
                prev_data = tx_data;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ready_mode == 1) tx_ready = 1'($urandom_range(0, 1));
            else if (ready_mode == 2) tx_ready = ~tx_ready;
        end
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        int nonk;
        logic [7:0] ob;
        logic [15:0] val;
        logic [7:0] exp_rsp;
        logic [7:0] bytes[$];

        tbl[0] = '{3, 8'h4C, 8'h00, 8'h00, 8'h45, 16'd300,   1'b0};
        tbl[1] = '{1, 8'h5A, 8'h00, 8'h00, 8'h45, 16'd300,   1'b0};
        tbl[2] = '{1, 8'h52, 8'h00, 8'h00, 8'h4B, 16'd300,   1'b1};
        tbl[3] = '{1, 8'h51, 8'h00, 8'h00, 8'h01, 16'd300,   1'b1};
        tbl[4] = '{3, 8'h4C, 8'hFF, 8'hFF, 8'h4B, 16'hFFFF,  1'b1};
        tbl[5] = '{3, 8'h4C, 8'h00, 8'h01, 8'h4B, 16'h0001,  1'b1};
        tbl[6] = '{1, 8'h6C, 8'h00, 8'h00, 8'h45, 16'h0001,  1'b1};
        tbl[7] = '{1, 8'h53, 8'h00, 8'h00, 8'h4B, 16'h0001,  1'b0};
        tbl[8] = '{1, 8'h51, 8'h00, 8'h00, 8'h00, 16'h0001,  1'b0};
        tbl[9] = '{3, 8'h4C, 8'h01, 8'h2C, 8'h4B, 16'd300,   1'b0};

        // Reset values; samp_valid is high but run is low, so no sample may move.
        idle(3);
        check("rst_delay", 32'(delay_len), DRST);
        check("rst_run", 32'(run), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        n_reset = 1'b1;
        idle(2);
        check("idle_tx_valid", 32'(tx_valid), 32'd0);
        check("idle_samp_ready", 32'(samp_ready), 32'd0);
        send_byte(8'h51);
        wait_rsp("rsp_first_query", 8'h00);
        samp_valid = 1'b0;

        // Commit timing and two-cycle response latency for 'L',0x01,0x2C.
        send_byte(8'h4C);
        send_byte(8'h01);
        @(negedge clk);
        rx_data  = 8'h2C;
        rx_valid = 1'b1;
        check("delay_before_commit", 32'(delay_len), DRST);
        @(negedge clk);
        rx_valid = 1'b0;
        check("delay_commit", 32'(delay_len), 32'd300);
        check("decode_cycle_tx_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("rsp_latency_valid", 32'(tx_valid), 32'd1);
        check("rsp_latency_data", 32'(tx_data), 32'h4B);
        wait_rsp("rsp_L_300", 8'h4B);

        for (int i = 0; i < 10; i++) begin
            send_byte(tbl[i].b0);
            if (tbl[i].n > 1) send_byte(tbl[i].b1);
            if (tbl[i].n > 2) send_byte(tbl[i].b2);
            wait_rsp($sformatf("tbl%0d_rsp", i), tbl[i].rsp);
            check($sformatf("tbl%0d_delay", i), 32'(delay_len), 32'(tbl[i].dly));
            check($sformatf("tbl%0d_run", i), 32'(run), 32'(tbl[i].run));
        end
        m_delay = 16'd300;

        // Sample streaming with a toggling tx_ready.
        rcv_q.delete();
        samp_loads = 0;
        samp_data  = 8'hA5;
        samp_valid = 1'b1;
        ready_mode = 2;
        send_byte(8'h52);
        idle(30);
        ready_mode = 0;
        tx_ready   = 1'b0;
        idle(2);
        samp_valid = 1'b0;
        check("stream_size_ok", 32'(rcv_q.size() >= 10), 32'd1);
        check("stream_first_K", 32'(rcv_q.size() > 0 ? rcv_q[0] : 8'h00), 32'h4B);
        nonk = 0;
        for (int i = 1; i < rcv_q.size(); i++) if (rcv_q[i] != 8'hA5) nonk++;
        check("stream_only_samples", 32'(nonk), 32'd0);
        check("held_sample_valid", 32'(tx_valid), 32'd1);
        check("held_sample_data", 32'(tx_data), 32'hA5);
        check("samp_ready_loads", 32'(samp_loads), 32'(rcv_q.size() - 1 + int'(tx_valid)));

        // Response blocked behind a held sample; a byte arriving then is dropped.
        rcv_q.delete();
        send_byte(8'h52);
        send_byte(8'h5A);
        idle(2);
        tx_ready = 1'b1;
        idle(4);
        check("overrun_rx_count", 32'(rcv_q.size()), 32'd2);
        check("overrun_rx0", 32'(rcv_q.size() > 0 ? rcv_q[0] : 8'h00), 32'hA5);
        check("overrun_rx1", 32'(rcv_q.size() > 1 ? rcv_q[1] : 8'h00), 32'h4B);
        rcv_q.delete();
        send_byte(8'h51);
        wait_rsp("status_overrun", 8'h03);
        send_byte(8'h51);
        wait_rsp("status_cleared", 8'h01);
        send_byte(8'h53);
        wait_rsp("stop_rsp", 8'h4B);

        // Stalled argument.
        rcv_q.delete();
        send_byte(8'h4C);
        send_byte(8'h12);
        idle(TMO + 50);
`ifdef HARNESS_CMD_TIMEOUT_EN
        wait_rsp("timeout_rsp", 8'h54);
        check("timeout_delay", 32'(delay_len), 32'(m_delay));
        send_byte(8'h34);
        wait_rsp("after_timeout_idle", 8'h45);
`else
        check("no_timeout_rsp", 32'(rcv_q.size()), 32'd0);
        send_byte(8'h34);
        wait_rsp("late_arg_rsp", 8'h4B);
        check("late_arg_delay", 32'(delay_len), 32'h1234);
`endif

        // Reset mid-argument with run=1 and a byte stuck in the tx register.
        send_byte(8'h52);
        wait_rsp("run_before_reset", 8'h4B);
        samp_valid = 1'b1;
        tx_ready   = 1'b0;
        idle(2);
        samp_valid = 1'b0;
        send_byte(8'h4C);
        send_byte(8'h56);
        @(negedge clk);
        n_reset = 1'b0;
        @(negedge clk);
        check("midrst_run", 32'(run), 32'd0);
        check("midrst_delay", 32'(delay_len), DRST);
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        n_reset  = 1'b1;
        tx_ready = 1'b1;
        rcv_q.delete();
        idle(2);
        send_byte(8'h53);
        wait_rsp("stop_after_reset", 8'h4B);
        send_byte(8'h51);
        wait_rsp("status_after_reset", 8'h00);

        // Random command stream against a command-level model.
        m_delay = DW'(DRST);
        m_run   = 1'b0;
        m_ovr   = 1'b0;
        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            bytes.delete();
            case ($urandom_range(0, 4))
                0: begin
                    val = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
                    bytes.push_back(8'h4C);
                    bytes.push_back(val[15:8]);
                    bytes.push_back(val[7:0]);
                    if (val != 16'h0000) begin
                        m_delay = val;
                        exp_rsp = 8'h4B;
                    end else begin
                        exp_rsp = 8'h45;
                    end
                end
                1: begin bytes.push_back(8'h52); m_run = 1'b1; exp_rsp = 8'h4B; end
                2: begin bytes.push_back(8'h53); m_run = 1'b0; exp_rsp = 8'h4B; end
                3: begin
                    bytes.push_back(8'h51);
                    exp_rsp = {6'b0, m_ovr, m_run};
                    m_ovr = 1'b0;
                end
                default: begin
                    do ob = 8'($urandom); while (ob inside {8'h4C, 8'h52, 8'h53, 8'h51});
                    bytes.push_back(ob);
                    exp_rsp = 8'h45;
                end
            endcase
            foreach (bytes[k]) begin
                send_byte(bytes[k]);
                idle($urandom_range(0, 2));
            end
            wait_rsp($sformatf("rand%0d_rsp", t), exp_rsp);
            check($sformatf("rand%0d_delay", t), 32'(delay_len), 32'(m_delay));
            check($sformatf("rand%0d_run", t), 32'(run), 32'(m_run));
        end
        ready_mode = 0;
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
